cur_blk_fetch: RTL

CUR_BLK_FETCH -- requirements
Module: cur_blk_fetch

---
 rtl/cur_blk_fetch.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/cur_blk_fetch.sv
// Current-picture 4x4 block fetcher for one CU.
// Issues one cur RAM read per block in raster order and hands blocks downstream.
module cur_blk_fetch #(
   parameter int LINE_WORDS = 32,
   parameter int RD_LAT     = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [12:0]   base_addr,
   input  logic [4:0]    cu_w4,
   input  logic [4:0]    cu_h4,
   output logic [12:0]   cur_addr0,
   output logic [12:0]   cur_addr1,
   output logic [12:0]   cur_addr2,
   output logic [12:0]   cur_addr3,
   output logic          export_data_cur,
   output logic          cur_en,
   input  logic [31:0]   cur_data0,
   input  logic [31:0]   cur_data1,
   input  logic [31:0]   cur_data2,
   input  logic [31:0]   cur_data3,
   output logic          blk_valid,
   input  logic          blk_ready,
   output logic [127:0]  blk_data,
   output logic [3:0]    blk_x,
   output logic [3:0]    blk_y,
   output logic          blk_last,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_OUT
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [12:0]         base_q, base_d;
   logic [4:0]          w_q, w_d;
   logic [4:0]          h_q, h_d;
   logic [3:0]          bx_q, bx_d;
   logic [3:0]          by_q, by_d;
   logic [3:0][12:0]    addr_q, addr_d;
   logic [127:0]        data_q, data_d;
   logic [3:0]          ox_q, ox_d;
   logic [3:0]          oy_q, oy_d;
   logic                last_q, last_d;
   logic                valid_q, valid_d;
   logic                done_q, done_d;
   logic                load;

   // Row N of block (x,y): base + (4y+N)*LINE_WORDS + x, wrapping at 13 bits.
   function automatic logic [12:0] row_addr(
      input logic [12:0] b,
      input logic [3:0]  x,
      input logic [3:0]  y,
      input logic [1:0]  n
   );
      logic [31:0] s;
      s = 32'(b) + 32'({y, n}) * 32'(LINE_WORDS) + 32'(x);
      return s[12:0];
   endfunction

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         w_q     <= 5'd1;
         h_q     <= 5'd1;
         bx_q    <= '0;
         by_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         ox_q    <= '0;
         oy_q    <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         w_q     <= w_d;
         h_q     <= h_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   // Next-state: request, wait out the RAM latency, present, advance raster.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      w_d     = w_q;
      h_d     = h_q;
      bx_d    = bx_q;
      by_d    = by_q;
      addr_d  = addr_q;
      data_d  = data_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      last_d  = last_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      load    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_REQ;
               base_d  = base_addr;
               w_d     = (cu_w4 == 5'd0) ? 5'd1 : cu_w4;
               h_d     = (cu_h4 == 5'd0) ? 5'd1 : cu_h4;
               bx_d    = '0;
               by_d    = '0;
               load    = 1'b1;
            end
         end
         S_REQ: begin
            state_d = S_WAIT;
            cnt_d   = '0;
         end
         S_WAIT: begin
            if (cnt_q == 2'(RD_LAT - 1)) begin
               state_d = S_OUT;
               data_d  = {cur_data3, cur_data2, cur_data1, cur_data0};
               ox_d    = bx_q;
               oy_d    = by_q;
               last_d  = (5'(bx_q) == w_q - 5'd1) &&
                         (5'(by_q) == h_q - 5'd1);
               valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         S_OUT: begin
            if (blk_ready) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               if (last_q) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_REQ;
                  load    = 1'b1;
                  if (5'(bx_q) == w_q - 5'd1) begin
                     bx_d = '0;
                     by_d = by_q + 4'd1;
                  end else begin
                     bx_d = bx_q + 4'd1;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (load) begin
         for (int n = 0; n < 4; n++) begin
            addr_d[n] = row_addr(base_d, bx_d, by_d, 2'(n));
         end
      end
   end

   assign export_data_cur = (state_q == S_REQ);
   assign cur_en          = (state_q != S_IDLE);
   assign cur_addr0       = addr_q[0];
   assign cur_addr1       = addr_q[1];
   assign cur_addr2       = addr_q[2];
   assign cur_addr3       = addr_q[3];
   assign blk_valid       = valid_q;
   assign blk_data        = data_q;
   assign blk_x           = ox_q;
   assign blk_y           = oy_q;
   assign blk_last        = last_q;
   assign done            = done_q;

endmodule
